// File: rtl/mul_64.sv
// Iterative shift-add 64x64 multiplier for RV64M MUL/MULH/MULHSU/MULHU.
// Optional early termination for narrow multipliers: define MUL_64_EARLY_OUT_EN.
module mul_64 #(
  parameter int WIDTH    = 64,
  parameter int CNT_BITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state;
  logic [PW-1:0]       p;
  logic [WIDTH-1:0]    ma;
  logic [1:0]          op_q;
  logic                neg;
  logic [CNT_BITS-1:0] cnt;

  // Operand conditioning at accept: magnitudes of the signed operands
  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_sgn = (op == 2'b01) || (op == 2'b10);
    b_sgn = (op == 2'b01);
    a_neg = a_sgn & a[WIDTH-1];
    b_neg = b_sgn & b[WIDTH-1];
    a_mag = a_neg ? (~a + 1'b1) : a;
    b_mag = b_neg ? (~b + 1'b1) : b;
  end

  // One shift-add step; the carry lands in the top bit of P
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend = p[0] ? ma : '0;
    sum    = {1'b0, p[PW-1:WIDTH]} + {1'b0, addend};
  end

  logic [CNT_BITS-1:0] last_cnt;
  logic [PW-1:0]       p_fix;
  logic [PW-1:0]       r;
  logic [PW-1:0]       p_init;

`ifdef MUL_64_EARLY_OUT_EN
  logic early, early_q;

  // A narrow multiplier only needs HALF iterations; the product then sits HALF bits high
  always_comb begin
    early    = ~|b_mag[WIDTH-1:HALF];
    p_init   = early ? {{WIDTH{1'b0}}, {HALF{1'b0}}, b_mag[HALF-1:0]}
                     : {{WIDTH{1'b0}}, b_mag};
    last_cnt = early_q ? CNT_BITS'(HALF - 1) : CNT_BITS'(WIDTH - 1);
    p_fix    = early_q ? (p >> HALF) : p;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      early_q <= 1'b0;
    else if (state == IDLE && in_valid && in_ready)
      early_q <= early;
  end
`else
  always_comb begin
    p_init   = {{WIDTH{1'b0}}, b_mag};
    last_cnt = CNT_BITS'(WIDTH - 1);
    p_fix    = p;
  end
`endif

  always_comb begin
    r = neg ? (~p_fix + 1'b1) : p_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      y         <= '0;
      p         <= '0;
      ma        <= '0;
      op_q      <= 2'b00;
      neg       <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ma       <= a_mag;
            p        <= p_init;
            neg      <= a_neg ^ b_neg;
            op_q     <= op;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          p   <= {sum, p[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == last_cnt)
            state <= FIX;
        end
        FIX: begin
          y         <= (op_q == 2'b00) ? r[WIDTH-1:0] : r[PW-1:WIDTH];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
